commit_trace_sequencer: RTL and testbench

Collects retiring instructions from the two writeback lanes of the pipeline, buffers them in a small in-order FIFO, and emits them one per cycle on the single `io_commit_*` trace port that the simulation top compares against the golden trace. It decouples the core's retire bandwidth (0–2 per cycle) from the trace checker (1 per cycle). It keeps program order, counts committed instructions, and flags protocol violations.

---
 rtl/commit_trace_sequencer.sv | 116 +++++++++++
 tb/tb_commit_trace_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_sequencer.sv
// Retire-to-trace sequencer: buffers up to two retiring instructions per cycle in an
// in-order FIFO and replays them one per cycle on the commit trace port.
module commit_trace_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid_0,
    input  logic        in_valid_1,
    input  logic [31:0] in_pc_0,
    input  logic [31:0] in_pc_1,
    input  logic [31:0] in_instr_0,
    input  logic [31:0] in_instr_1,
    input  logic        in_wen_0,
    input  logic        in_wen_1,
    input  logic [4:0]  in_waddr_0,
    input  logic [4:0]  in_waddr_1,
    input  logic [31:0] in_wdata_0,
    input  logic [31:0] in_wdata_1,
    output logic        in_ready,
    input  logic        drain_en,
    output logic        io_commit_valid,
    output logic [31:0] io_commit_pc,
    output logic [31:0] io_commit_instr,
    output logic        io_commit_wen,
    output logic [4:0]  io_commit_waddr,
    output logic [31:0] io_commit_wdata,
    output logic [31:0] ninstr,
    output logic        overflow_err,
    output logic        order_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        lane0, lane1;
    entry_t        out_q, out_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   ninstr_q, ninstr_d;
    logic          overflow_q, overflow_d, order_q, order_d;
    logic          push0, push1, pop;

    // Ready looks only at the registered occupancy, so a pop this cycle cannot help.
    assign in_ready = (DEPTH_C - count_q) >= CW'(2);

    always_comb begin
        lane0 = '{pc: in_pc_0, instr: in_instr_0, wen: in_wen_0 && (in_waddr_0 != 5'd0),
                  waddr: in_waddr_0, wdata: in_wdata_0};
        lane1 = '{pc: in_pc_1, instr: in_instr_1, wen: in_wen_1 && (in_waddr_1 != 5'd0),
                  waddr: in_waddr_1, wdata: in_wdata_1};

        push0 = in_ready && in_valid_0;
        push1 = in_ready && in_valid_0 && in_valid_1;
        pop   = (count_q != '0) && drain_en;

        wptr_d  = wptr_q + AW'(push0) + AW'(push1);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);

        valid_d  = pop;
        out_d    = pop ? mem_q[rptr_q] : out_q;
        ninstr_d = ninstr_q + 32'(pop);

        overflow_d = overflow_q || (!in_ready && (in_valid_0 || in_valid_1));
        order_d    = order_q || (in_valid_1 && !in_valid_0);
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push0) mem_q[wptr_q] <= lane0;
        if (push1) mem_q[wptr_q + AW'(1)] <= lane1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            out_q      <= '0;
            ninstr_q   <= '0;
            overflow_q <= 1'b0;
            order_q    <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
            ninstr_q   <= ninstr_d;
            overflow_q <= overflow_d;
            order_q    <= order_d;
        end
    end

    assign io_commit_valid = valid_q;
    assign io_commit_pc    = out_q.pc;
    assign io_commit_instr = out_q.instr;
    assign io_commit_wen   = out_q.wen;
    assign io_commit_waddr = out_q.waddr;
    assign io_commit_wdata = out_q.wdata;
    assign ninstr          = ninstr_q;
    assign overflow_err    = overflow_q;
    assign order_err       = order_q;
endmodule

// File: tb/tb_commit_trace_sequencer.sv
// Directed bench for commit_trace_sequencer: hand-computed expectations for reset,
// dual retire, backpressure, protocol errors, pointer wrap and mid-stream reset.
module tb_commit_trace_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid_0, in_valid_1;
    logic [31:0] in_pc_0, in_pc_1, in_instr_0, in_instr_1;
    logic        in_wen_0, in_wen_1;
    logic [4:0]  in_waddr_0, in_waddr_1;
    logic [31:0] in_wdata_0, in_wdata_1;
    logic        in_ready, drain_en;
    logic        io_commit_valid, io_commit_wen;
    logic [31:0] io_commit_pc, io_commit_instr, io_commit_wdata, ninstr;
    logic [4:0]  io_commit_waddr;
    logic        overflow_err, order_err;

    int assertCount = 0;
    int failCount   = 0;

    commit_trace_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
        .in_pc_0(in_pc_0), .in_pc_1(in_pc_1),
        .in_instr_0(in_instr_0), .in_instr_1(in_instr_1),
        .in_wen_0(in_wen_0), .in_wen_1(in_wen_1),
        .in_waddr_0(in_waddr_0), .in_waddr_1(in_waddr_1),
        .in_wdata_0(in_wdata_0), .in_wdata_1(in_wdata_1),
        .in_ready(in_ready), .drain_en(drain_en),
        .io_commit_valid(io_commit_valid), .io_commit_pc(io_commit_pc),
        .io_commit_instr(io_commit_instr), .io_commit_wen(io_commit_wen),
        .io_commit_waddr(io_commit_waddr), .io_commit_wdata(io_commit_wdata),
        .ninstr(ninstr), .overflow_err(overflow_err), .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of retire traffic; instr/wen/waddr/wdata are derived from the pc.
    task automatic applyStimulus(input logic v0, input logic v1, input logic [31:0] pc0,
                                 input logic [31:0] pc1, input logic drain);
        in_valid_0 = v0;          in_valid_1 = v1;
        in_pc_0    = pc0;         in_pc_1    = pc1;
        in_instr_0 = pc0 + 32'h13; in_instr_1 = pc1 + 32'h13;
        in_wen_0   = 1'b1;        in_wen_1   = 1'b1;
        in_waddr_0 = 5'd1;        in_waddr_1 = 5'd2;
        in_wdata_0 = ~pc0;        in_wdata_1 = ~pc1;
        drain_en   = drain;
        step();
        in_valid_0 = 1'b0;
        in_valid_1 = 1'b0;
    endtask

    initial begin
        logic [31:0] expPcs [4];
        int pushed, commits;

        reset = 1'b1; drain_en = 1'b0;
        in_valid_0 = 1'b0; in_valid_1 = 1'b0;
        in_pc_0 = '0; in_pc_1 = '0; in_instr_0 = '0; in_instr_1 = '0;
        in_wen_0 = 1'b0; in_wen_1 = 1'b0; in_waddr_0 = '0; in_waddr_1 = '0;
        in_wdata_0 = '0; in_wdata_1 = '0;

        // Reset values and quiet idle period
        step(); step();
        reset = 1'b0;
        checkOutput("rst valid", 32'(io_commit_valid), 32'd0);
        checkOutput("rst pc", io_commit_pc, 32'd0);
        checkOutput("rst instr", io_commit_instr, 32'd0);
        checkOutput("rst wen", 32'(io_commit_wen), 32'd0);
        checkOutput("rst waddr", 32'(io_commit_waddr), 32'd0);
        checkOutput("rst wdata", io_commit_wdata, 32'd0);
        checkOutput("rst ninstr", ninstr, 32'd0);
        checkOutput("rst overflow", 32'(overflow_err), 32'd0);
        checkOutput("rst order", 32'(order_err), 32'd0);
        checkOutput("rst ready", 32'(in_ready), 32'd1);
        drain_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("idle valid", 32'(io_commit_valid), 32'd0);
        end

        // Dual retire: lane 0 emerges first, lane 1 one cycle later
        applyStimulus(1'b1, 1'b1, 32'hbfc00000, 32'hbfc00004, 1'b1);
        checkOutput("dual N valid", 32'(io_commit_valid), 32'd0);
        step();
        checkOutput("dual N+1 valid", 32'(io_commit_valid), 32'd1);
        checkOutput("dual N+1 pc", io_commit_pc, 32'hbfc00000);
        checkOutput("dual N+1 instr", io_commit_instr, 32'hbfc00013);
        checkOutput("dual N+1 ninstr", ninstr, 32'd1);
        step();
        checkOutput("dual N+2 valid", 32'(io_commit_valid), 32'd1);
        checkOutput("dual N+2 pc", io_commit_pc, 32'hbfc00004);
        checkOutput("dual N+2 wen", 32'(io_commit_wen), 32'd1);
        checkOutput("dual N+2 waddr", 32'(io_commit_waddr), 32'd2);
        checkOutput("dual N+2 wdata", io_commit_wdata, ~32'hbfc00004);
        checkOutput("dual N+2 ninstr", ninstr, 32'd2);
        step();
        checkOutput("dual drained valid", 32'(io_commit_valid), 32'd0);
        checkOutput("dual hold pc", io_commit_pc, 32'hbfc00004);
        checkOutput("dual ready", 32'(in_ready), 32'd1);

        // Backpressure and overflow
        applyStimulus(1'b1, 1'b1, 32'h100, 32'h104, 1'b0);
        checkOutput("bp ready after 2", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h108, 32'h10c, 1'b0);
        checkOutput("bp ready full", 32'(in_ready), 32'd0);
        checkOutput("bp no overflow yet", 32'(overflow_err), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h110, 32'h114, 1'b0);
        checkOutput("bp overflow", 32'(overflow_err), 32'd1);
        checkOutput("bp no commit", 32'(io_commit_valid), 32'd0);
        expPcs[0] = 32'h100; expPcs[1] = 32'h104; expPcs[2] = 32'h108; expPcs[3] = 32'h10c;
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("bp pop valid", 32'(io_commit_valid), 32'd1);
            checkOutput("bp pop pc", io_commit_pc, expPcs[i]);
            checkOutput("bp pop ready", 32'(in_ready), (i == 0) ? 32'd0 : 32'd1);
        end
        step();
        checkOutput("bp no fifth", 32'(io_commit_valid), 32'd0);
        checkOutput("bp ninstr", ninstr, 32'd6);

        // Order violation, then wen normalisation for waddr 0
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h200, 1'b1);
        checkOutput("order err", 32'(order_err), 32'd1);
        step();
        checkOutput("order no commit", 32'(io_commit_valid), 32'd0);
        checkOutput("order ninstr", ninstr, 32'd6);
        in_valid_0 = 1'b1; in_pc_0 = 32'h300; in_wen_0 = 1'b1;
        in_waddr_0 = 5'd0; in_wdata_0 = 32'h1234;
        step();
        in_valid_0 = 1'b0;
        step();
        checkOutput("norm valid", 32'(io_commit_valid), 32'd1);
        checkOutput("norm pc", io_commit_pc, 32'h300);
        checkOutput("norm wen", 32'(io_commit_wen), 32'd0);
        checkOutput("norm wdata", io_commit_wdata, 32'h1234);
        checkOutput("sticky overflow", 32'(overflow_err), 32'd1);
        checkOutput("sticky order", 32'(order_err), 32'd1);

        // Pointer wrap with intermittent draining, from a fresh reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("wrap rst overflow", 32'(overflow_err), 32'd0);
        checkOutput("wrap rst order", 32'(order_err), 32'd0);
        pushed = 0;
        commits = 0;
        in_wen_0 = 1'b1; in_waddr_0 = 5'd3;
        for (int cyc = 0; cyc < 200 && commits < 10; cyc++) begin
            in_valid_0 = (pushed < 10) && in_ready;
            in_pc_0    = 32'(pushed * 4);
            in_instr_0 = in_pc_0 + 32'h13;
            in_wdata_0 = ~in_pc_0;
            drain_en   = (cyc % 2) == 0;
            @(posedge clk);
            if (in_valid_0) pushed++;
            #1;
            in_valid_0 = 1'b0;
            if (io_commit_valid) begin
                checkOutput("wrap pc", io_commit_pc, 32'(commits * 4));
                commits++;
            end
        end
        checkOutput("wrap commits", 32'(commits), 32'd10);
        checkOutput("wrap ninstr", ninstr, 32'd10);
        checkOutput("wrap overflow", 32'(overflow_err), 32'd0);
        drain_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("wrap no extra", 32'(io_commit_valid), 32'd0);
        end

        // Reset while entries are queued
        applyStimulus(1'b1, 1'b1, 32'h400, 32'h404, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h408, 32'h0, 1'b0);
        reset = 1'b1; drain_en = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("mid rst valid", 32'(io_commit_valid), 32'd0);
        checkOutput("mid rst ninstr", ninstr, 32'd0);
        checkOutput("mid rst pc", io_commit_pc, 32'd0);
        step();
        checkOutput("mid post valid", 32'(io_commit_valid), 32'd0);
        checkOutput("mid post ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1'b1);
        step();
        checkOutput("mid push valid", 32'(io_commit_valid), 32'd1);
        checkOutput("mid push pc", io_commit_pc, 32'h80);
        checkOutput("mid push ninstr", ninstr, 32'd1);
        step();
        checkOutput("mid push single", 32'(io_commit_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
